// File: rtl/seven_seg_disp_sel.sv
// Source selector for the seven-segment display word: CPU GPIO register or one of NCH debug taps,
// chosen manually or by a dwell-timed auto-scan. disp_num is fully registered.
module seven_seg_disp_sel #(
  parameter int               DATA_W    = 32,
  parameter int               NCH       = 7,
  parameter int               SEL_W     = 3,
  parameter int               SCAN_DIV  = 50_000_000,
  parameter logic [NCH-1:0]   WADDR_MSK = '0,
  parameter logic [31:0]      RST_VAL   = 32'h12345678
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cpu_we,
  input  logic [DATA_W-1:0]     cpu_data,
  input  logic [SEL_W-1:0]      test_sel,
  input  logic                  auto_scan,
  input  logic                  freeze,
  input  logic [NCH*DATA_W-1:0] test_data,
  output logic [DATA_W-1:0]     disp_num,
  output logic [SEL_W-1:0]      cur_src,
  output logic                  scan_tick
);

  localparam int                CNT_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DATA_W-1:0] RST_WORD = DATA_W'(RST_VAL);
  localparam logic [SEL_W-1:0]  LAST_SRC = SEL_W'(NCH);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(SCAN_DIV - 1);

  logic [DATA_W-1:0] cpu_reg;
  logic [SEL_W-1:0]  scan_idx;
  logic [CNT_W-1:0]  dwell_cnt;
  logic              auto_scan_d;

  logic              scan_edge;
  logic              scan_wrap;
  logic [SEL_W-1:0]  start_idx;
  logic [SEL_W-1:0]  scan_cur;
  logic [SEL_W-1:0]  scan_nxt;
  logic [CNT_W-1:0]  cnt_cur;
  logic [SEL_W-1:0]  src;
  logic [DATA_W-1:0] tap;
  logic [DATA_W-1:0] nxt_num;

  // On the rising edge of auto_scan the restart values are used in the same cycle,
  // so the first dwell period is exactly SCAN_DIV cycles long.
  always_comb begin
    scan_edge = auto_scan & ~auto_scan_d;
    start_idx = (test_sel > LAST_SRC) ? '0 : test_sel;
    scan_cur  = scan_edge ? start_idx : scan_idx;
    cnt_cur   = scan_edge ? '0 : dwell_cnt;
    src       = auto_scan ? scan_cur : test_sel;
    scan_wrap = auto_scan && (cnt_cur == LAST_CNT);
    scan_nxt  = (scan_cur == LAST_SRC) ? '0 : scan_cur + 1'b1;

    tap     = '0;
    nxt_num = disp_num;
    if (src == '0)
      nxt_num = cpu_we ? cpu_data : cpu_reg;
    for (int k = 1; k <= NCH; k++) begin
      if (src == SEL_W'(k)) begin
        tap     = test_data[k*DATA_W-1 -: DATA_W];
        nxt_num = WADDR_MSK[k-1] ? (tap >> 2) : tap;
      end
    end
  end

  // cpu_reg ignores freeze; everything else, including the edge detector, stalls under freeze.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cpu_reg     <= RST_WORD;
      disp_num    <= RST_WORD;
      cur_src     <= '0;
      scan_idx    <= '0;
      dwell_cnt   <= '0;
      auto_scan_d <= 1'b0;
      scan_tick   <= 1'b0;
    end else begin
      if (cpu_we)
        cpu_reg <= cpu_data;
      if (freeze) begin
        scan_tick <= 1'b0;
      end else begin
        auto_scan_d <= auto_scan;
        disp_num    <= nxt_num;
        cur_src     <= src;
        scan_tick   <= scan_wrap;
        if (!auto_scan) begin
          dwell_cnt <= '0;
        end else if (scan_wrap) begin
          dwell_cnt <= '0;
          scan_idx  <= scan_nxt;
        end else begin
          dwell_cnt <= cnt_cur + 1'b1;
          scan_idx  <= scan_cur;
        end
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_disp_sel.sv
// Directed bench for seven_seg_disp_sel: a 7-tap instance with a short dwell and word-address tap 1,
// plus a 5-tap instance for out-of-range selects.
module tb_seven_seg_disp_sel;

  logic          clk;
  logic          reset_n;
  logic          cpu_we;
  logic [31:0]   cpu_data;
  logic [2:0]    test_sel;
  logic          auto_scan;
  logic          freeze;
  logic [223:0]  test_data;
  logic [31:0]   taps [1:7];
  logic [31:0]   disp_num;
  logic [2:0]    cur_src;
  logic          scan_tick;
  logic [31:0]   disp_num5;
  logic [2:0]    cur_src5;
  logic          scan_tick5;

  int checks   = 0;
  int failures = 0;

  seven_seg_disp_sel #(
    .DATA_W(32), .NCH(7), .SEL_W(3), .SCAN_DIV(4),
    .WADDR_MSK(7'b0000001), .RST_VAL(32'h12345678)
  ) u_dut (
    .clk(clk), .reset_n(reset_n), .cpu_we(cpu_we), .cpu_data(cpu_data),
    .test_sel(test_sel), .auto_scan(auto_scan), .freeze(freeze),
    .test_data(test_data), .disp_num(disp_num), .cur_src(cur_src), .scan_tick(scan_tick)
  );

  seven_seg_disp_sel #(
    .DATA_W(32), .NCH(5), .SEL_W(3), .SCAN_DIV(4),
    .WADDR_MSK(5'b00000), .RST_VAL(32'h12345678)
  ) u_dut5 (
    .clk(clk), .reset_n(reset_n), .cpu_we(cpu_we), .cpu_data(cpu_data),
    .test_sel(test_sel), .auto_scan(auto_scan), .freeze(freeze),
    .test_data(test_data[159:0]), .disp_num(disp_num5), .cur_src(cur_src5), .scan_tick(scan_tick5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    test_data = '0;
    for (int k = 1; k <= 7; k++)
      test_data[k*32-1 -: 32] = taps[k];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) tick();
    checks++; if (disp_num !== 32'h12345678) begin failures++; $display("[TB] FAIL reset_disp got=%h exp=%h", disp_num, 32'h12345678); end
    checks++; if (cur_src !== 3'd0) begin failures++; $display("[TB] FAIL reset_src got=%0d exp=0", cur_src); end
    checks++; if (scan_tick !== 1'b0) begin failures++; $display("[TB] FAIL reset_tick got=%b exp=0", scan_tick); end
    reset_n = 1'b1;
    tick();
    checks++; if (disp_num !== 32'h12345678) begin failures++; $display("[TB] FAIL post_reset_cpu_reg got=%h exp=%h", disp_num, 32'h12345678); end
  endtask

  task automatic test_cpu_path();
    test_sel = 3'd0; cpu_we = 1'b1; cpu_data = 32'hCAFEF00D;
    tick();
    cpu_we = 1'b0;
    checks++; if (disp_num !== 32'hCAFEF00D) begin failures++; $display("[TB] FAIL cpu_bypass got=%h exp=%h", disp_num, 32'hCAFEF00D); end
    tick();
    checks++; if (disp_num !== 32'hCAFEF00D) begin failures++; $display("[TB] FAIL cpu_reg_hold got=%h exp=%h", disp_num, 32'hCAFEF00D); end
    test_sel = 3'd3; cpu_we = 1'b1; cpu_data = 32'h0BADBEEF;
    tick();
    cpu_we = 1'b0;
    checks++; if (disp_num !== 32'h33333333) begin failures++; $display("[TB] FAIL store_other_src got=%h exp=%h", disp_num, 32'h33333333); end
    checks++; if (cur_src !== 3'd3) begin failures++; $display("[TB] FAIL store_other_cur got=%0d exp=3", cur_src); end
    test_sel = 3'd0;
    tick();
    checks++; if (disp_num !== 32'h0BADBEEF) begin failures++; $display("[TB] FAIL stored_shown got=%h exp=%h", disp_num, 32'h0BADBEEF); end
  endtask

  task automatic test_taps();
    test_sel = 3'd1;
    tick();
    checks++; if (disp_num !== 32'h00100004) begin failures++; $display("[TB] FAIL tap1_waddr got=%h exp=%h", disp_num, 32'h00100004); end
    checks++; if (cur_src !== 3'd1) begin failures++; $display("[TB] FAIL tap1_cur got=%0d exp=1", cur_src); end
    test_sel = 3'd2;
    tick();
    checks++; if (disp_num !== 32'hA5A5A5A5) begin failures++; $display("[TB] FAIL tap2_raw got=%h exp=%h", disp_num, 32'hA5A5A5A5); end
    test_sel = 3'd7;
    tick();
    checks++; if (disp_num !== 32'h77777777) begin failures++; $display("[TB] FAIL tap7_last got=%h exp=%h", disp_num, 32'h77777777); end
  endtask

  task automatic test_auto_scan();
    logic [2:0]  exp_src  [4];
    logic [31:0] exp_word [4];
    exp_src  = '{3'd6, 3'd7, 3'd0, 3'd1};
    exp_word = '{32'h66666666, 32'h77777777, 32'h0BADBEEF, 32'h00100004};
    test_sel = 3'd6;
    tick();
    auto_scan = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      checks++; if (cur_src !== exp_src[(i-1)/4]) begin failures++; $display("[TB] FAIL scan_src[%0d] got=%0d exp=%0d", i, cur_src, exp_src[(i-1)/4]); end
      checks++; if (disp_num !== exp_word[(i-1)/4]) begin failures++; $display("[TB] FAIL scan_disp[%0d] got=%h exp=%h", i, disp_num, exp_word[(i-1)/4]); end
      checks++; if (scan_tick !== (i % 4 == 0)) begin failures++; $display("[TB] FAIL scan_tick[%0d] got=%b exp=%b", i, scan_tick, (i % 4 == 0)); end
    end
  endtask

  task automatic test_freeze();
    repeat (2) tick();
    checks++; if (cur_src !== 3'd2) begin failures++; $display("[TB] FAIL pre_freeze_src got=%0d exp=2", cur_src); end
    freeze = 1'b1; taps[2] = 32'hDEADBEEF; cpu_we = 1'b1; cpu_data = 32'h13579BDF;
    for (int i = 0; i < 10; i++) begin
      tick();
      cpu_we = 1'b0;
      checks++; if (disp_num !== 32'hA5A5A5A5 || cur_src !== 3'd2 || scan_tick !== 1'b0) begin
        failures++; $display("[TB] FAIL freeze_hold[%0d] got=%h/%0d/%b exp=a5a5a5a5/2/0", i, disp_num, cur_src, scan_tick);
      end
    end
    freeze = 1'b0;
    tick();
    checks++; if (disp_num !== 32'hDEADBEEF || scan_tick !== 1'b0) begin failures++; $display("[TB] FAIL release_update got=%h/%b exp=deadbeef/0", disp_num, scan_tick); end
    tick();
    checks++; if (scan_tick !== 1'b1 || cur_src !== 3'd2) begin failures++; $display("[TB] FAIL resume_tick got=%b/%0d exp=1/2", scan_tick, cur_src); end
    tick();
    checks++; if (cur_src !== 3'd3 || scan_tick !== 1'b0) begin failures++; $display("[TB] FAIL resume_next got=%0d/%b exp=3/0", cur_src, scan_tick); end
    auto_scan = 1'b0; test_sel = 3'd0;
    tick();
    checks++; if (disp_num !== 32'h13579BDF) begin failures++; $display("[TB] FAIL frozen_cpu_load got=%h exp=%h", disp_num, 32'h13579BDF); end
  endtask

  task automatic test_out_of_range();
    test_sel = 3'd7;
    tick();
    checks++; if (disp_num5 !== 32'h13579BDF) begin failures++; $display("[TB] FAIL oor_hold got=%h exp=%h", disp_num5, 32'h13579BDF); end
    checks++; if (cur_src5 !== 3'd7) begin failures++; $display("[TB] FAIL oor_cur got=%0d exp=7", cur_src5); end
    checks++; if (disp_num !== 32'h77777777) begin failures++; $display("[TB] FAIL nch_edge got=%h exp=%h", disp_num, 32'h77777777); end
    taps[5] = 32'h0; test_sel = 3'd6;
    tick();
    checks++; if (disp_num5 !== 32'h13579BDF || cur_src5 !== 3'd6) begin failures++; $display("[TB] FAIL oor_hold6 got=%h/%0d exp=13579bdf/6", disp_num5, cur_src5); end
    test_sel = 3'd7; auto_scan = 1'b1;
    tick();
    checks++; if (cur_src5 !== 3'd0 || scan_tick5 !== 1'b0) begin failures++; $display("[TB] FAIL oor_scan_start got=%0d/%b exp=0/0", cur_src5, scan_tick5); end
    checks++; if (cur_src !== 3'd7) begin failures++; $display("[TB] FAIL scan_start7 got=%0d exp=7", cur_src); end
    auto_scan = 1'b0; taps[5] = 32'h55555555; test_sel = 3'd0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] words [3];
    words = '{32'h11111111, 32'h22222222, 32'h33330000};
    test_sel = 3'd0;
    for (int i = 0; i < 3; i++) begin
      cpu_we = 1'b1; cpu_data = words[i];
      tick();
      checks++; if (disp_num !== words[i]) begin failures++; $display("[TB] FAIL b2b_store[%0d] got=%h exp=%h", i, disp_num, words[i]); end
    end
    test_sel = 3'd4; cpu_data = 32'h99999999;
    tick();
    cpu_we = 1'b0;
    checks++; if (disp_num !== 32'h44444444) begin failures++; $display("[TB] FAIL b2b_other got=%h exp=%h", disp_num, 32'h44444444); end
    test_sel = 3'd0;
    tick();
    checks++; if (disp_num !== 32'h99999999) begin failures++; $display("[TB] FAIL b2b_reg got=%h exp=%h", disp_num, 32'h99999999); end
  endtask

  task automatic test_reset_mid_scan();
    test_sel = 3'd2; auto_scan = 1'b1;
    repeat (4) tick();
    checks++; if (scan_tick !== 1'b1 || cur_src !== 3'd2) begin failures++; $display("[TB] FAIL mid_scan_state got=%b/%0d exp=1/2", scan_tick, cur_src); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (disp_num !== 32'h12345678) begin failures++; $display("[TB] FAIL async_disp got=%h exp=%h", disp_num, 32'h12345678); end
    checks++; if (cur_src !== 3'd0) begin failures++; $display("[TB] FAIL async_src got=%0d exp=0", cur_src); end
    checks++; if (scan_tick !== 1'b0) begin failures++; $display("[TB] FAIL async_tick got=%b exp=0", scan_tick); end
    repeat (2) tick();
    auto_scan = 1'b0;
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    reset_n = 1'b0; cpu_we = 1'b0; cpu_data = '0; test_sel = '0;
    auto_scan = 1'b0; freeze = 1'b0;
    taps[1] = 32'h00400010; taps[2] = 32'hA5A5A5A5; taps[3] = 32'h33333333;
    taps[4] = 32'h44444444; taps[5] = 32'h55555555; taps[6] = 32'h66666666;
    taps[7] = 32'h77777777;
    test_reset();
    test_cpu_path();
    test_taps();
    test_auto_scan();
    test_freeze();
    test_out_of_range();
    test_back_to_back();
    test_reset_mid_scan();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
